reflet_mdu: RTL
===============

Name: reflet_mdu

Overview:
- Iterative multiply/divide unit: a parametrised multi-cycle companion to the single-cycle combinational ALU.
- Performs unsigned multiply (low or high half), divide and remainder on wordsize-bit operands.
- Results come back with zero and divide-by-zero flags.
- Sits beside the ALU in the execute stage and is driven by the control FSM through a valid/ready handshake on both input and output.

Parameters:
- wordsize, 16, operand/result width in bits; any value >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; returns the unit to IDLE.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request.
- op  input  2  0=MUL (low half), 1=MULH (high half), 2=DIV (quotient), 3=MOD (remainder).
- op_a  input  wordsize  multiplicand / dividend.
- op_b  input  wordsize  multiplier / divisor.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result  output  wordsize  operation result.
- flag_zero  output  1  result == 0.
- flag_div0  output  1  DIV/MOD issued with op_b == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - result=0; flag_zero=0; flag_div0=0.
  - All internal registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, capture op, op_a, op_b; load iteration counter with wordsize (counter width clog2(wordsize+1)).
  - Next state is RUN, except DIV/MOD with op_b==0, which goes straight to DONE.
- RUN (in_ready=0), one iteration per cycle:
  - MUL/MULH: shift-add over a 2*wordsize product.
    - If multiplier bit0 is set, product += multiplicand, where the multiplicand register is 2*wordsize wide.
    - Then shift the multiplicand left 1 and the multiplier right 1.
  - DIV/MOD: restoring division with a wordsize+1 bit partial remainder.
    - Shift remainder left 1 and bring in the MSB of the dividend.
    - Trial-subtract the divisor; if non-negative, keep the difference and shift 1 into the quotient, else shift 0.
  - Counter decrements each cycle. When the counter reaches 0 after the final iteration, go to DONE.
- Latency: request accepted at edge N; out_valid rises after edge N+wordsize+1 (wordsize iterations plus one DONE-entry cycle). Divide-by-zero: out_valid after edge N+1.
- Result selection, registered on DONE entry:
  - MUL: product[wordsize-1:0].
  - MULH: product[2*wordsize-1:wordsize].
  - DIV: quotient.
  - MOD: remainder[wordsize-1:0].
- Divide by zero: quotient = all ones, remainder = op_a, flag_div0=1. flag_div0=0 for every other operation.
- flag_zero is computed on the selected result.
- DONE:
  - out_valid=1; result and flags held stable while out_ready=0 (indefinite backpressure allowed).
  - On out_ready, next state is IDLE and out_valid=0 next cycle.
  - A new request is accepted no earlier than the cycle after the handshake (no back-to-back overlap).
  - result and flags keep their last values in IDLE.
- flush: in any state, forces IDLE on the next edge with out_valid=0. Any in-flight result is discarded; flags unchanged. flush has priority over in_valid and out_ready in the same cycle.
- Inputs are sampled only at acceptance; changes to op_a/op_b/op during RUN have no effect.
- Undefined op encodings: none; all four are defined.

Optional Feature:
- Macro REFLET_MDU_EARLY_EXIT_EN.
- Defined: for MUL/MULH, RUN exits to DONE in the cycle after the remaining multiplier register becomes 0. Latency is (index of highest set bit of op_b)+2 cycles. op_b==0 takes 1 iteration, so out_valid appears after edge N+2. Results are bit-identical. DIV/MOD are unchanged.
- Not defined: every operation except divide-by-zero takes exactly wordsize iterations.

Test Plan:
- MUL 7*6, wordsize=16 -> result=0x002A, flag_zero=0, out_valid exactly 17 cycles after acceptance (early-exit off).
- MULH then MUL of 0xFFFF*0xFFFF -> MULH=0xFFFE, MUL=0x0001; MUL 0x0000*0x1234 -> result=0, flag_zero=1.
- DIV 100/7 -> 0x000E; MOD 100/7 -> 0x0002; MOD 5/9 -> 0x0005, DIV 5/9 -> 0, flag_zero=1.
- DIV 0x1234/0 -> result=0xFFFF, flag_div0=1, out_valid after 1 cycle; MOD 0x1234/0 -> 0x1234, flag_div0=1.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles -> result/flags stable, in_ready=0, in_valid ignored.
  - Release out_ready -> IDLE, then next request accepted.
  - Assert reset mid-RUN -> all outputs return to reset values immediately, without waiting for a clock edge.
- flush at RUN iteration 5 with in_valid=1 -> IDLE next cycle, no out_valid, request not accepted that cycle. A following MUL 3*3 -> 0x0009.

Source files
------------

// File: rtl/reflet_mdu.sv
// Iterative unsigned multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle. Optional REFLET_MDU_EARLY_EXIT_EN ends multiplies once the multiplier is exhausted.
module reflet_mdu #(
  parameter int wordsize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          op,
  input  logic [wordsize-1:0] op_a,
  input  logic [wordsize-1:0] op_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [wordsize-1:0] result,
  output logic                flag_zero,
  output logic                flag_div0,
  output logic                busy
);

  localparam int W  = wordsize;
  localparam int W2 = 2 * wordsize;
  localparam int CW = $clog2(wordsize + 1);

  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_MULH = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_MOD  = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      op_reg, op_next;
  logic [W2-1:0]   mcand_reg, mcand_next;
  logic [W-1:0]    mplier_reg, mplier_next;
  logic [W2-1:0]   prod_reg, prod_next;
  logic [W:0]      rem_reg, rem_next;
  logic [W-1:0]    quot_reg, quot_next;
  logic [W-1:0]    dvd_reg, dvd_next;
  logic [W-1:0]    dvs_reg, dvs_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [W-1:0]    result_reg, result_next;
  logic            flag_zero_reg, flag_zero_next;
  logic            flag_div0_reg, flag_div0_next;

  logic [W:0]      rem_shifted;
  logic [W:0]      rem_diff;
  logic [W-1:0]    sel_result;
  logic            run_done;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign result    = result_reg;
  assign flag_zero = flag_zero_reg;
  assign flag_div0 = flag_div0_reg;

  // Partial remainder never exceeds the divisor, so W+1 bits hold the shifted trial value.
  assign rem_shifted = {rem_reg[W-1:0], dvd_reg[W-1]};
  assign rem_diff    = rem_shifted - {1'b0, dvs_reg};

  always_comb begin
    sel_result = quot_reg;
    case (op_reg)
      OP_MUL:  sel_result = prod_reg[W-1:0];
      OP_MULH: sel_result = prod_reg[W2-1:W];
      OP_DIV:  sel_result = quot_reg;
      OP_MOD:  sel_result = rem_reg[W-1:0];
      default: sel_result = quot_reg;
    endcase
  end

`ifdef REFLET_MDU_EARLY_EXIT_EN
  // At least one iteration always runs, hence the counter must have moved off its load value.
  assign run_done = (cnt_reg == '0) ||
                    (~op_reg[1] && (mplier_reg == '0) && (cnt_reg != CW'(W)));
`else
  assign run_done = (cnt_reg == '0);
`endif

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    mcand_next     = mcand_reg;
    mplier_next    = mplier_reg;
    prod_next      = prod_reg;
    rem_next       = rem_reg;
    quot_next      = quot_reg;
    dvd_next       = dvd_reg;
    dvs_next       = dvs_reg;
    cnt_next       = cnt_reg;
    result_next    = result_reg;
    flag_zero_next = flag_zero_reg;
    flag_div0_next = flag_div0_reg;

    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_next     = op;
            mcand_next  = {{W{1'b0}}, op_a};
            mplier_next = op_b;
            prod_next   = '0;
            rem_next    = '0;
            quot_next   = '0;
            dvd_next    = op_a;
            dvs_next    = op_b;
            cnt_next    = CW'(W);
            if (op[1] && (op_b == '0)) begin
              state_next     = DONE;
              result_next    = (op == OP_DIV) ? '1 : op_a;
              flag_zero_next = (op == OP_DIV) ? 1'b0 : (op_a == '0);
              flag_div0_next = 1'b1;
            end else begin
              state_next = RUN;
            end
          end
        end
        RUN: begin
          if (run_done) begin
            state_next     = DONE;
            result_next    = sel_result;
            flag_zero_next = (sel_result == '0);
            flag_div0_next = 1'b0;
          end else begin
            // Both datapaths step every cycle; only the one matching op_reg is selected at the end.
            if (mplier_reg[0])
              prod_next = prod_reg + mcand_reg;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            rem_next    = rem_diff[W] ? rem_shifted : rem_diff;
            quot_next   = {quot_reg[W-2:0], ~rem_diff[W]};
            dvd_next    = dvd_reg << 1;
            cnt_next    = cnt_reg - CW'(1);
          end
        end
        DONE: begin
          if (out_ready)
            state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      prod_reg      <= '0;
      rem_reg       <= '0;
      quot_reg      <= '0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      cnt_reg       <= '0;
      result_reg    <= '0;
      flag_zero_reg <= 1'b0;
      flag_div0_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      mcand_reg     <= mcand_next;
      mplier_reg    <= mplier_next;
      prod_reg      <= prod_next;
      rem_reg       <= rem_next;
      quot_reg      <= quot_next;
      dvd_reg       <= dvd_next;
      dvs_reg       <= dvs_next;
      cnt_reg       <= cnt_next;
      result_reg    <= result_next;
      flag_zero_reg <= flag_zero_next;
      flag_div0_reg <= flag_div0_next;
    end
  end

endmodule
